// File: rtl/parking_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : parking_timer_display
// Description : Parking-meter mm:ss up-counter with a 4-digit multiplexed
//               7-segment display and a blinking colon.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_timer_display (
    input  logic       clk_40MHz,
    input  logic       rst,
    input  logic       clk_100Hz,
    input  logic       clk_2Hz,
    input  logic       clk_1Hz,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    localparam logic [6:0] c_BLANK = 7'h7F;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_mm_t, r_mm_o, r_ss_t, r_ss_o;
    logic [3:0] w_mm_t, w_mm_o, w_ss_t, w_ss_o;
    logic       r_prev_100hz, r_prev_1hz;
    logic       w_tick_100hz, w_tick_1hz;
    logic       w_at_max;
    logic [1:0] r_scan_idx;
    logic [3:0] w_digit;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;
    logic       w_colon;

    assign w_tick_100hz = clk_100Hz & ~r_prev_100hz;
    assign w_tick_1hz   = clk_1Hz & ~r_prev_1hz;
    assign w_at_max     = (r_mm_t == 4'd9) && (r_mm_o == 4'd9) &&
                          (r_ss_t == 4'd5) && (r_ss_o == 4'd9);

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mm_t  <= 4'd0;
            r_mm_o  <= 4'd0;
            r_ss_t  <= 4'd0;
            r_ss_o  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mm_t  <= w_mm_t;
            r_mm_o  <= w_mm_o;
            r_ss_t  <= w_ss_t;
            r_ss_o  <= w_ss_o;
        end
    end

    // clear > stop > start; a start edge swallows any coincident second tick
    always_comb begin
        w_state_nxt = r_state;
        w_mm_t      = r_mm_t;
        w_mm_o      = r_mm_o;
        w_ss_t      = r_ss_t;
        w_ss_o      = r_ss_o;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_mm_t      = 4'd0;
            w_mm_o      = 4'd0;
            w_ss_t      = 4'd0;
            w_ss_o      = 4'd0;
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSED;
            end
        end else if (start && (r_state == S_IDLE || r_state == S_PAUSED)) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN && w_tick_1hz) begin
            if (w_at_max) begin
                w_state_nxt = S_FULL;
            end else if (r_ss_o != 4'd9) begin
                w_ss_o = r_ss_o + 4'd1;
            end else begin
                w_ss_o = 4'd0;
                if (r_ss_t != 4'd5) begin
                    w_ss_t = r_ss_t + 4'd1;
                end else begin
                    w_ss_t = 4'd0;
                    if (r_mm_o != 4'd9) begin
                        w_mm_o = r_mm_o + 4'd1;
                    end else begin
                        w_mm_o = 4'd0;
                        w_mm_t = r_mm_t + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        case (r_scan_idx)
            2'd0:    w_digit = r_ss_o;
            2'd1:    w_digit = r_ss_t;
            2'd2:    w_digit = r_mm_o;
            default: w_digit = r_mm_t;
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_seg_nxt = 7'h40;
            4'd1:    w_seg_nxt = 7'h79;
            4'd2:    w_seg_nxt = 7'h24;
            4'd3:    w_seg_nxt = 7'h30;
            4'd4:    w_seg_nxt = 7'h19;
            4'd5:    w_seg_nxt = 7'h12;
            4'd6:    w_seg_nxt = 7'h02;
            4'd7:    w_seg_nxt = 7'h78;
            4'd8:    w_seg_nxt = 7'h00;
            4'd9:    w_seg_nxt = 7'h10;
            default: w_seg_nxt = c_BLANK;
        endcase
        // colon sits on digit 2; it blinks with the 2 Hz level while counting
        w_colon  = (r_scan_idx == 2'd2) &&
                   (r_state == S_IDLE || r_state == S_PAUSED || clk_2Hz);
        w_dp_nxt = ~w_colon;
        if (r_state == S_FULL && !clk_2Hz) begin
            w_seg_nxt = c_BLANK;
            w_dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            r_prev_100hz <= 1'b0;
            r_prev_1hz   <= 1'b0;
            r_scan_idx   <= 2'd0;
            seg          <= c_BLANK;
            an           <= 4'hF;
            dp           <= 1'b1;
            running      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_prev_100hz <= clk_100Hz;
            r_prev_1hz   <= clk_1Hz;
            if (w_tick_100hz) begin
                r_scan_idx <= r_scan_idx + 2'd1;
            end
            seg      <= w_seg_nxt;
            an       <= ~(4'b0001 << r_scan_idx);
            dp       <= w_dp_nxt;
            running  <= (w_state_nxt == S_RUN);
            overflow <= (w_state_nxt == S_FULL);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_timer_display.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_parking_timer_display
// Description : Self-checking bench; reference model keeps time as a plain
//               seconds count and derives display digits arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_timer_display;

    logic       clk_40MHz = 1'b0;
    logic       rst, clk_100Hz, clk_2Hz, clk_1Hz, start, stop, clear;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp, running, overflow;

    parking_timer_display dut (
        .clk_40MHz (clk_40MHz),
        .rst       (rst),
        .clk_100Hz (clk_100Hz),
        .clk_2Hz   (clk_2Hz),
        .clk_1Hz   (clk_1Hz),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .running   (running),
        .overflow  (overflow)
    );

    always #12.5 clk_40MHz = ~clk_40MHz;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_FULL = 3;

    int         m_state, m_secs, m_idx;
    logic       m_p100, m_p1;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_dp, m_run, m_ovf;
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;

    // lit segments of each decimal digit, by letter
    string seg_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] pattern(int d);
        logic [6:0] p;
        string s;
        p = 7'h7F;
        s = seg_lit[d];
        for (int i = 0; i < s.len(); i++) p[s[i] - 8'h61] = 1'b0;
        return p;
    endfunction

    function automatic int digit_of(int secs, int idx);
        case (idx)
            0:       return (secs % 60) % 10;
            1:       return (secs % 60) / 10;
            2:       return (secs / 60) % 10;
            default: return secs / 600;
        endcase
    endfunction

    function automatic bit lit_up(int st, logic blink);
        return !(st == M_FULL && !blink);
    endfunction

    function automatic logic model_dp(int st, int idx, logic blink);
        bit colon;
        colon = (idx == 2) && (st == M_IDLE || st == M_PAUSED || blink);
        return !(colon && lit_up(st, blink));
    endfunction

    function automatic int next_state(int st, int secs, bit t1, logic clr, logic stp, logic sta);
        if (clr) return M_IDLE;
        if (stp) return (st == M_RUN) ? M_PAUSED : st;
        if (sta && (st == M_IDLE || st == M_PAUSED)) return M_RUN;
        if (st == M_RUN && t1 && secs == 5999) return M_FULL;
        return st;
    endfunction

    function automatic int next_secs(int st, int secs, bit t1, logic clr, logic stp, logic sta);
        if (clr) return 0;
        if (stp) return secs;
        if (sta && (st == M_IDLE || st == M_PAUSED)) return secs;
        if (st == M_RUN && t1 && secs < 5999) return secs + 1;
        return secs;
    endfunction

    always @(posedge clk_40MHz) begin
        if (rst) begin
            m_state <= M_IDLE;
            m_secs  <= 0;
            m_idx   <= 0;
            m_p100  <= 1'b0;
            m_p1    <= 1'b0;
            m_seg   <= 7'h7F;
            m_an    <= 4'hF;
            m_dp    <= 1'b1;
            m_run   <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_seg   <= lit_up(m_state, clk_2Hz) ? pattern(digit_of(m_secs, m_idx)) : 7'h7F;
            m_an    <= ~(4'b0001 << m_idx);
            m_dp    <= model_dp(m_state, m_idx, clk_2Hz);
            m_p100  <= clk_100Hz;
            m_p1    <= clk_1Hz;
            if (clk_100Hz && !m_p100) m_idx <= (m_idx + 1) % 4;
            m_state <= next_state(m_state, m_secs, clk_1Hz && !m_p1, clear, stop, start);
            m_secs  <= next_secs(m_state, m_secs, clk_1Hz && !m_p1, clear, stop, start);
            m_run   <= next_state(m_state, m_secs, clk_1Hz && !m_p1, clear, stop, start) == M_RUN;
            m_ovf   <= next_state(m_state, m_secs, clk_1Hz && !m_p1, clear, stop, start) == M_FULL;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one cycle: wait for the falling edge, compare all outputs to the model
    task automatic step();
        @(negedge clk_40MHz);
        if (chk_en) begin
            n_vec++;
            if ({seg, an, dp, running, overflow} !== {m_seg, m_an, m_dp, m_run, m_ovf}) begin
                n_err++;
                $display("FAIL cycle t=%0t: seg=%h an=%b dp=%b run=%b ovf=%b, expected seg=%h an=%b dp=%b run=%b ovf=%b",
                         $time, seg, an, dp, running, overflow, m_seg, m_an, m_dp, m_run, m_ovf);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_1hz();
        clk_1Hz = 1'b1; step();
        clk_1Hz = 1'b0; step();
    endtask

    task automatic pulse_100hz();
        clk_100Hz = 1'b1; step();
        clk_100Hz = 1'b0; step();
    endtask

    task automatic random_phase(input int n, input bit allow_clr);
        for (int i = 0; i < n; i++) begin
            start = ($urandom % 16) == 0;
            stop  = ($urandom % 24) == 0;
            clear = allow_clr && (($urandom % 64) == 0);
            rst   = allow_clr && (($urandom % 500) == 0);
            if ($urandom % 3 == 0) clk_1Hz = ~clk_1Hz;
            if ($urandom % 2 == 0) clk_100Hz = ~clk_100Hz;
            if ($urandom % 8 == 0) clk_2Hz = ~clk_2Hz;
            step();
        end
        {start, stop, clear, rst, clk_1Hz, clk_100Hz} = '0;
        step();
    endtask

    logic [3:0] an_seq [8] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                               4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic       dp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1;
        {clk_100Hz, clk_2Hz, clk_1Hz, start, stop, clear} = '0;
        step();
        chk_en = 1'b1;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp", dp, 1'b1);
        check("rst_flags", {running, overflow}, 2'b00);
        cycles(2);
        rst = 1'b0;
        step();

        // five seconds of counting
        start = 1'b1; step(); start = 1'b0;
        repeat (5) pulse_1hz();
        check("five_secs", m_secs, 5);
        check("five_run", running, 1'b1);
        check("five_an", an, 4'b1110);
        check("five_seg", seg, 7'h12);

        // 00:59 -> 01:00
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (59) pulse_1hz();
        check("secs_59", m_secs, 59);
        clk_1Hz = 1'b1; step();
        check("secs_60", m_secs, 60);
        clk_1Hz = 1'b0; clk_2Hz = 1'b1;
        pulse_100hz(); pulse_100hz();
        check("min_an", an, 4'b1011);
        check("min_seg", seg, 7'h79);
        check("min_dp", dp, 1'b0);

        // stop or start coinciding with a tick never increments
        stop = 1'b1; clk_1Hz = 1'b1; step();
        stop = 1'b0; clk_1Hz = 1'b0; step();
        check("stop_tick_secs", m_secs, 60);
        check("stop_tick_state", m_state, M_PAUSED);
        check("stop_tick_run", running, 1'b0);
        start = 1'b1; clk_1Hz = 1'b1; step();
        start = 1'b0; clk_1Hz = 1'b0; step();
        check("start_tick_secs", m_secs, 60);
        check("start_tick_run", running, 1'b1);

        // all three controls at once: clear wins
        {clear, stop, start} = 3'b111; step();
        {clear, stop, start} = 3'b000; step();
        check("all3_run", running, 1'b0);
        check("all3_secs", m_secs, 0);
        check("all3_state", m_state, M_IDLE);

        random_phase(2000, 1'b1);

        // scan sequence and mid-scan reset
        rst = 1'b1; step(); rst = 1'b0; clk_2Hz = 1'b0; step();
        for (int k = 0; k < 8; k++) begin
            pulse_100hz();
            check("scan_an", an, an_seq[k]);
            check("scan_dp", dp, dp_seq[k]);
        end
        pulse_100hz();
        clk_100Hz = 1'b1; rst = 1'b1; step();
        check("midscan_rst_an", an, 4'hF);
        check("midscan_rst_seg", seg, 7'h7F);
        clk_100Hz = 1'b0; rst = 1'b0; step();

        // run to 99:59 and overflow
        start = 1'b1; step(); start = 1'b0;
        repeat (5999) pulse_1hz();
        check("max_secs", m_secs, 5999);
        check("max_flags", {running, overflow}, 2'b10);
        pulse_1hz();
        check("full_secs", m_secs, 5999);
        check("full_state", m_state, M_FULL);
        check("full_flags", {running, overflow}, 2'b01);
        clk_2Hz = 1'b0; cycles(2);
        check("full_blank_seg", seg, 7'h7F);
        check("full_blank_dp", dp, 1'b1);
        clk_2Hz = 1'b1; cycles(2);
        check("full_show_an", an, 4'b1110);
        check("full_show_seg", seg, 7'h10);
        random_phase(500, 1'b0);
        check("full_sticky", m_state, M_FULL);
        clear = 1'b1; step(); clear = 1'b0; step();
        check("clr_flags", {running, overflow}, 2'b00);
        check("clr_secs", m_secs, 0);

        random_phase(1500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
